pc_redirect_unit: RTL and testbench
===================================

PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and target width in bits.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..3, number of cycles flush is held after a redirect.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port branch_taken  input  1  resolved conditional-branch decision from the EX-stage branch unit.
REQ-007 SHALL have port jump  input  1  JAL/JALR in EX.
REQ-008 SHALL have port target  input  XLEN  redirect address, valid when branch_taken or jump is 1.
REQ-009 SHALL have port stall  input  1  load-use hazard stall; holds PC.
REQ-010 SHALL have port imem_ready  input  1  instruction memory accepted fetch at pc this cycle.
REQ-011 SHALL have port pc  output  XLEN  current fetch address, registered.
REQ-012 SHALL have port pc_plus4  output  XLEN  pc + 4 modulo 2^XLEN, combinational from pc.
REQ-013 SHALL have port flush  output  1  squash IF/ID and ID/EX; decoded from state only.
REQ-014 SHALL have port fetch_valid  output  1  0 only in HALT.
REQ-015 SHALL have port misalign_err  output  1  sticky; redirect to target[1:0] != 0 occurred.
REQ-016 SHALL have port bad_addr  output  XLEN  offending target captured on misalign.
REQ-017 SHALL have port redirect_count  output  16  accepted aligned redirects, saturating.

Function
REQ-018 SHALL implement FSM states RUN, FLUSH, HALT; redirect_req = branch_taken | jump.
REQ-019 In RUN with redirect_req and target[1:0] == 0: pc <= target regardless of stall or imem_ready; state -> FLUSH; flush counter <= FLUSH_CYCLES-1; redirect_count increments unless 16'hFFFF.
REQ-020 In RUN with redirect_req and target[1:0] != 0: pc holds; misalign_err <= 1; bad_addr <= target; state -> HALT; redirect_count unchanged.
REQ-021 In RUN without redirect_req: pc <= pc + 4 (wrap modulo 2^XLEN) iff !stall && imem_ready; else pc holds.
REQ-022 Priority in RUN: misaligned redirect > aligned redirect > stall > imem_ready.
REQ-023 In FLUSH: flush = 1; branch_taken, jump, target and stall ignored; pc <= pc + 4 iff imem_ready.
REQ-024 In FLUSH: counter decrements each cycle; at counter == 0 state -> RUN next edge; flush therefore high exactly FLUSH_CYCLES cycles after the redirect edge.
REQ-025 In HALT: pc, bad_addr, redirect_count frozen; flush = 1; fetch_valid = 0; exit only by rst.
REQ-026 flush = 0 and fetch_valid = 1 in RUN.
REQ-027 pc_plus4 of 32'hFFFF_FFFC SHALL be 32'h0000_0000.
REQ-028 Redirect latency: target appears on pc one cycle after the edge sampling redirect_req.

Reset
REQ-029 On rst = 1, asynchronously: pc = RESET_PC, state = RUN, counter = 0, flush = 0, fetch_valid = 1, misalign_err = 0, bad_addr = 0, redirect_count = 0.
REQ-030 Reset asserted mid-FLUSH or in HALT SHALL abort the state immediately; first edge after deassertion behaves per RUN.

Verification
REQ-031 Reset, imem_ready = 1 for 3 cycles, no stall -> pc 0x0, 0x4, 0x8, 0xC; flush 0.
REQ-032 pc = 0x10, branch_taken = 1, target = 0x100, stall = 1 -> next pc 0x100; flush high 2 cycles; redirect_count = 1; pc = 0x104, 0x108 during flush with imem_ready = 1.
REQ-033 During FLUSH, jump = 1, target = 0x200 -> ignored; pc continues +4; redirect_count unchanged.
REQ-034 jump = 1, target = 0x102 -> misalign_err = 1, bad_addr = 0x102, fetch_valid = 0, pc frozen; later redirects ignored until rst.
REQ-035 pc = 0xFFFF_FFFC, imem_ready = 1 -> pc = 0x0; stall = 1 or imem_ready = 0 -> pc holds.
REQ-036 redirect_count preset to 0xFFFF via 65535 redirects -> further redirect keeps 0xFFFF; rst asserted mid-FLUSH -> flush drops to 0 asynchronously, pc = RESET_PC.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// Fetch PC sequencer: redirects land on pc one cycle after the sampling edge, then flush for FLUSH_CYCLES.
// Advance is throttled by stall/imem_ready; a misaligned redirect halts fetch until reset.
module pc_redirect_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = '0,
   parameter int              FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            branch_taken,
   input  logic            jump,
   input  logic [XLEN-1:0] target,
   input  logic            stall,
   input  logic            imem_ready,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            flush,
   output logic            fetch_valid,
   output logic            misalign_err,
   output logic [XLEN-1:0] bad_addr,
   output logic [15:0]     redirect_count
);

   localparam logic [1:0]      ST_RUN     = 2'd0;
   localparam logic [1:0]      ST_FLUSH   = 2'd1;
   localparam logic [1:0]      ST_HALT    = 2'd2;
   localparam logic [1:0]      FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

   logic [1:0]      state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            misalign_q, misalign_d;
   logic [XLEN-1:0] bad_addr_q, bad_addr_d;
   logic [15:0]     redirect_count_q, redirect_count_d;
   logic            redirect_req;

   assign redirect_req = branch_taken | jump;
   assign pc_plus4     = pc_q + PC_STEP;

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      pc_d             = pc_q;
      misalign_d       = misalign_q;
      bad_addr_d       = bad_addr_q;
      redirect_count_d = redirect_count_q;
      case (state_q)
         ST_RUN: begin
            if (redirect_req) begin
               if (target[1:0] != 2'b00) begin
                  misalign_d = 1'b1;
                  bad_addr_d = target;
                  state_d    = ST_HALT;
               end else begin
                  pc_d    = target;
                  state_d = ST_FLUSH;
                  cnt_d   = FLUSH_INIT;
                  if (redirect_count_q != 16'hFFFF)
                     redirect_count_d = redirect_count_q + 16'd1;
               end
            end else if (!stall && imem_ready) begin
               pc_d = pc_plus4;
            end
         end
         ST_FLUSH: begin
            // Redirect inputs and stall are stale here; the squashed stages own them.
            if (imem_ready)
               pc_d = pc_plus4;
            if (cnt_q == 2'd0)
               state_d = ST_RUN;
            else
               cnt_d = cnt_q - 2'd1;
         end
         ST_HALT: begin
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_RUN;
         cnt_q            <= 2'd0;
         pc_q             <= RESET_PC;
         misalign_q       <= 1'b0;
         bad_addr_q       <= '0;
         redirect_count_q <= 16'd0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         pc_q             <= pc_d;
         misalign_q       <= misalign_d;
         bad_addr_q       <= bad_addr_d;
         redirect_count_q <= redirect_count_d;
      end
   end

   assign pc             = pc_q;
   assign flush          = (state_q != ST_RUN);
   assign fetch_valid    = (state_q != ST_HALT);
   assign misalign_err   = misalign_q;
   assign bad_addr       = bad_addr_q;
   assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with hand-computed expectations.
module tb_pc_redirect_unit;

   logic        clk;
   logic        rst;
   logic        branch_taken;
   logic        jump;
   logic [31:0] target;
   logic        stall;
   logic        imem_ready;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        flush;
   logic        fetch_valid;
   logic        misalign_err;
   logic [31:0] bad_addr;
   logic [15:0] redirect_count;

   int n_checks = 0;
   int n_errors = 0;

   pc_redirect_unit #(
      .XLEN(32),
      .RESET_PC(32'h0000_0000),
      .FLUSH_CYCLES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .branch_taken(branch_taken),
      .jump(jump),
      .target(target),
      .stall(stall),
      .imem_ready(imem_ready),
      .pc(pc),
      .pc_plus4(pc_plus4),
      .flush(flush),
      .fetch_valid(fetch_valid),
      .misalign_err(misalign_err),
      .bad_addr(bad_addr),
      .redirect_count(redirect_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic bt, input logic jp, input logic [31:0] tg,
                        input logic st, input logic rdy);
      branch_taken = bt;
      jump         = jp;
      target       = tg;
      stall        = st;
      imem_ready   = rdy;
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 32'h0, 0, 0);
      #1;
      check_eq("rst_pc", pc, 32'h0);
      check_eq("rst_flush", 32'(flush), 32'h0);
      check_eq("rst_fetch_valid", 32'(fetch_valid), 32'h1);
      check_eq("rst_misalign", 32'(misalign_err), 32'h0);
      check_eq("rst_bad_addr", bad_addr, 32'h0);
      check_eq("rst_count", 32'(redirect_count), 32'h0);

      // Sequential fetch
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 32'h0, 0, 1);
      tick(); check_eq("seq_pc4", pc, 32'h4);
      tick(); check_eq("seq_pc8", pc, 32'h8);
      tick(); check_eq("seq_pcC", pc, 32'hC);
      check_eq("seq_flush", 32'(flush), 32'h0);
      tick(); check_eq("seq_pc10", pc, 32'h10);

      drive(0, 0, 32'h0, 1, 1);
      tick(); check_eq("stall_hold", pc, 32'h10);
      drive(0, 0, 32'h0, 0, 0);
      tick(); check_eq("notready_hold", pc, 32'h10);

      // Aligned redirect beats stall
      drive(1, 0, 32'h100, 1, 1);
      tick();
      check_eq("redir_pc", pc, 32'h100);
      check_eq("redir_flush", 32'(flush), 32'h1);
      check_eq("redir_count", 32'(redirect_count), 32'h1);
      // Redirect and stall ignored while flushing
      drive(0, 1, 32'h200, 1, 1);
      tick();
      check_eq("flush1_pc", pc, 32'h104);
      check_eq("flush1_flush", 32'(flush), 32'h1);
      check_eq("flush1_count", 32'(redirect_count), 32'h1);
      tick();
      check_eq("flush2_pc", pc, 32'h108);
      check_eq("flush_end", 32'(flush), 32'h0);
      check_eq("flush_end_count", 32'(redirect_count), 32'h1);

      // Misaligned redirect halts
      drive(0, 1, 32'h102, 0, 1);
      tick();
      check_eq("mis_err", 32'(misalign_err), 32'h1);
      check_eq("mis_bad_addr", bad_addr, 32'h102);
      check_eq("mis_fetch_valid", 32'(fetch_valid), 32'h0);
      check_eq("mis_flush", 32'(flush), 32'h1);
      check_eq("mis_pc", pc, 32'h108);
      check_eq("mis_count", 32'(redirect_count), 32'h1);
      drive(1, 0, 32'h300, 0, 1);
      tick(); tick();
      check_eq("halt_pc", pc, 32'h108);
      check_eq("halt_count", 32'(redirect_count), 32'h1);
      check_eq("halt_bad_addr", bad_addr, 32'h102);
      check_eq("halt_fetch_valid", 32'(fetch_valid), 32'h0);

      rst = 1'b1;
      #1;
      check_eq("halt_rst_misalign", 32'(misalign_err), 32'h0);
      check_eq("halt_rst_fetch_valid", 32'(fetch_valid), 32'h1);
      rst = 1'b0;

      // PC wrap at top of address space
      drive(1, 0, 32'hFFFF_FFFC, 0, 0);
      tick();
      check_eq("wrap_redir_pc", pc, 32'hFFFF_FFFC);
      drive(0, 0, 32'h0, 0, 0);
      tick(); tick();
      check_eq("wrap_run_flush", 32'(flush), 32'h0);
      check_eq("wrap_pc_plus4", pc_plus4, 32'h0);
      drive(0, 0, 32'h0, 1, 1);
      tick(); check_eq("wrap_stall_hold", pc, 32'hFFFF_FFFC);
      drive(0, 0, 32'h0, 0, 0);
      tick(); check_eq("wrap_notready_hold", pc, 32'hFFFF_FFFC);
      drive(0, 0, 32'h0, 0, 1);
      tick(); check_eq("wrap_pc", pc, 32'h0);

      // Counter saturation, starting one below the ceiling
      drive(0, 0, 32'h0, 0, 0);
      force dut.redirect_count_q = 16'hFFFE;
      tick();
      release dut.redirect_count_q;
      #1;
      check_eq("preset_count", 32'(redirect_count), 32'hFFFE);
      drive(0, 1, 32'h40, 0, 0);
      tick();
      check_eq("sat_reach", 32'(redirect_count), 32'hFFFF);
      drive(0, 0, 32'h0, 0, 0);
      tick(); tick();
      check_eq("sat_run_pc", pc, 32'h40);
      drive(1, 0, 32'h80, 0, 0);
      tick();
      check_eq("sat_hold", 32'(redirect_count), 32'hFFFF);
      check_eq("sat_pc", pc, 32'h80);
      check_eq("sat_flush", 32'(flush), 32'h1);

      // Asynchronous reset mid-flush
      drive(0, 0, 32'h0, 0, 1);
      rst = 1'b1;
      #1;
      check_eq("arst_flush", 32'(flush), 32'h0);
      check_eq("arst_pc", pc, 32'h0);
      check_eq("arst_count", 32'(redirect_count), 32'h0);
      rst = 1'b0;
      tick();
      check_eq("post_rst_pc", pc, 32'h4);
      check_eq("post_rst_flush", 32'(flush), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
